// File: rtl/custom_isa_pkg.sv
// Shared encodings and FSM states for the custom-extension execution core.
package custom_isa_pkg;

  localparam logic [6:0] OP_CUST = 7'h77;
  localparam logic [6:0] OP_BR   = 7'h7F;

  localparam logic [2:0] F3_SQADD  = 3'b000;
  localparam logic [2:0] F3_MULSUB = 3'b001;
  localparam logic [2:0] F3_BITCNT = 3'b010;
  localparam logic [2:0] F3_XORI   = 3'b100;
  localparam logic [2:0] F3_ADDI   = 3'b101;
  localparam logic [2:0] F3_SELBR  = 3'b111;

  localparam logic [1:0] SEL_NOP  = 2'b00;
  localparam logic [1:0] SEL_BEQ  = 2'b01;
  localparam logic [1:0] SEL_BLTU = 2'b10;
  localparam logic [1:0] SEL_BGEU = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MUL_A, S_MUL_B, S_WB} state_e;

endpackage

// File: rtl/custom_isa_core_mc_seq_mul.sv
// Shift-add multiplier retiring one multiplier bit per cycle; p is the low XLEN bits.
module seq_mul #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] p
);
  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, mcand_q, mplier_q;

  // p already includes the partial product of the step in flight, so it is
  // final during the done cycle and stays final once the multiplier drains.
  assign p    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done = (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= CW'(XLEN);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
    end else if (cnt_q != '0) begin
      acc_q    <= p;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/custom_isa_core_mc.sv
// Multi-cycle core for opcodes 0x77/0x7F: single-cycle ALU/branch ops, iterative SQADD/MULSUB.
module custom_isa_core_mc
  import custom_isa_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              NREG      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter bit              BYTE_SWAP = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [31:0]          instr,
  output logic [XLEN-1:0]      pc,
  output logic                 busy,
  output logic                 illegal,
  output logic [NREG*XLEN-1:0] regs_flat
);
  localparam int RW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, opnd_q, opnd_d, sq1_q, sq1_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic            sqadd_q, sqadd_d, illegal_q, illegal_d;
  logic            we;
  logic [RW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            mul_start, mul_done;
  logic [XLEN-1:0] mul_a, mul_b, mul_p;

  logic [31:0]     ins;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [RW-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1v, rs2v, imm12, bimm, jimm;
  logic            taken;

  function automatic logic [XLEN-1:0] popcnt(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] c;
    c = '0;
    for (int i = 0; i < XLEN; i++) c = c + XLEN'(v[i]);
    return c;
  endfunction

  assign ins     = BYTE_SWAP ? {instr[7:0], instr[15:8], instr[23:16], instr[31:24]} : instr;
  assign opcode  = ins[6:0];
  assign f3      = ins[14:12];
  assign rd_idx  = ins[7 +: RW];
  assign rs1_idx = ins[15 +: RW];
  assign rs2_idx = ins[20 +: RW];
  assign rs1v    = regs_q[rs1_idx];
  assign rs2v    = regs_q[rs2_idx];
  assign imm12   = XLEN'(ins[31:20]);
  assign bimm    = XLEN'($signed({ins[7], ins[29:25], ins[11:8], 1'b0}));
  assign jimm    = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

  always_comb begin
    taken = 1'b0;
    case (ins[31:30])
      SEL_BEQ:  taken = (rs1v == rs2v);
      SEL_BLTU: taken = (rs1v < rs2v);
      SEL_BGEU: taken = (rs1v >= rs2v);
      default:  taken = 1'b0;
    endcase
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = ~instr_ready;
  assign pc          = pc_q;
  assign illegal     = illegal_q;

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*XLEN +: XLEN] = regs_q[g];
  end

  seq_mul #(.XLEN(XLEN)) u_mul (
    .clk  (clk),
    .reset(reset),
    .start(mul_start),
    .a    (mul_a),
    .b    (mul_b),
    .done (mul_done),
    .p    (mul_p)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = 1'b0;
    opnd_d    = opnd_q;
    sq1_d     = sq1_q;
    rd_d      = rd_q;
    sqadd_d   = sqadd_q;
    we        = 1'b0;
    wa        = rd_idx;
    wd        = '0;
    mul_start = 1'b0;
    mul_a     = rs1v;
    mul_b     = rs2v;
    case (state_q)
      S_IDLE: if (instr_valid) begin
        pc_d = pc_q + XLEN'(4);
        if (opcode == OP_CUST) begin
          case (f3)
            F3_SQADD, F3_MULSUB: begin
              // pc advances only at writeback, so hold it here
              pc_d      = pc_q;
              mul_start = 1'b1;
              sqadd_d   = (f3 == F3_SQADD);
              mul_b     = (f3 == F3_SQADD) ? rs1v : rs2v;
              opnd_d    = (f3 == F3_SQADD) ? rs2v : rs1v;
              rd_d      = rd_idx;
              state_d   = S_MUL_A;
            end
            F3_BITCNT: begin we = 1'b1; wd = popcnt(ins[31] ? rs1v : ~rs1v); end
            F3_XORI:   begin we = 1'b1; wd = rs1v ^ imm12; end
            F3_ADDI:   begin we = 1'b1; wd = rs1v + imm12; end
            default:   illegal_d = 1'b1;
          endcase
        end else if (opcode == OP_BR) begin
          if (f3 == F3_SELBR) begin
            if (taken) pc_d = pc_q + bimm;
          end else begin
            we   = 1'b1;
            wd   = pc_q + XLEN'(4);
            pc_d = pc_q + (jimm << 1);
          end
        end else begin
          illegal_d = 1'b1;
        end
      end
      S_MUL_A: if (mul_done) begin
        if (sqadd_q) begin
          sq1_d     = mul_p;
          mul_start = 1'b1;
          mul_a     = opnd_q;
          mul_b     = opnd_q;
          state_d   = S_MUL_B;
        end else begin
          state_d = S_WB;
        end
      end
      S_MUL_B: if (mul_done) state_d = S_WB;
      S_WB: begin
        we      = 1'b1;
        wa      = rd_q;
        wd      = sqadd_q ? (sq1_q + mul_p) : (mul_p - opnd_q);
        pc_d    = pc_q + XLEN'(4);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
      if (we && wa != '0) regs_q[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    opnd_q  <= opnd_d;
    sq1_q   <= sq1_d;
    rd_q    <= rd_d;
    sqadd_q <= sqadd_d;
  end

endmodule

// File: tb/tb_custom_isa_core_mc.sv
// Directed bench for custom_isa_core_mc with byte-reversed instruction delivery.
module tb_custom_isa_core_mc;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [31:0]          instr;
  logic [XLEN-1:0]      pc;
  logic                 busy;
  logic                 illegal;
  logic [NREG*XLEN-1:0] regs_flat;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  custom_isa_core_mc #(
    .XLEN(XLEN), .NREG(NREG), .RESET_PC(32'h0), .BYTE_SWAP(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .pc         (pc),
    .busy       (busy),
    .illegal    (illegal),
    .regs_flat  (regs_flat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rg(input int i);
    return regs_flat[i*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b101, rd, 7'h77};
  endfunction

  function automatic logic [31:0] xori(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b100, rd, 7'h77};
  endfunction

  function automatic logic [31:0] rr(input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, f3, rd, 7'h77};
  endfunction

  function automatic logic [31:0] bitcnt(input logic b31, input logic [4:0] rd, input logic [4:0] rs1);
    return {b31, 11'b0, rs1, 3'b010, rd, 7'h77};
  endfunction

  function automatic logic [31:0] selbr(input logic [1:0] s, input logic [4:0] rs1, input logic [4:0] rs2, input logic [10:0] off);
    return {s, off[9:5], rs2, rs1, 3'b111, off[4:1], off[10], 7'h7F};
  endfunction

  function automatic logic [31:0] jal2(input logic [4:0] rd, input logic [20:0] j);
    return {j[20], j[10:1], j[11], j[19:12], rd, 7'h7F};
  endfunction

  // Enters and leaves at a falling edge; on return the result cycle is current.
  task automatic run(input logic [31:0] ins, input int nbusy);
    int n;
    int t;
    t = 0;
    while (!instr_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rdy_before", 32'(instr_ready), 32'd1);
    instr       = bsw(ins);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    if (nbusy == 0) instr_valid = 1'b0;
    else instr = bsw(addi(5'd31, 5'd0, 12'h5A5));
    n = 0;
    for (int i = 1; i <= nbusy; i++) begin
      @(negedge clk);
      if (busy && !instr_ready) n++;
      if (i == nbusy) instr_valid = 1'b0;
    end
    if (nbusy > 0) check("busy_len", n, nbusy);
    @(negedge clk);
    check("rdy_after", 32'(instr_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_pc", pc, 32'h0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_regs", 32'(|regs_flat), 32'd0);

    run(addi(5'd1, 5'd0, 12'd3), 0);
    check("addi_x1", rg(1), 32'd3);
    check("addi_pc", pc, 32'h4);
    run(addi(5'd2, 5'd0, 12'd4), 0);
    run(rr(3'b000, 5'd3, 5'd1, 5'd2), 65);
    check("sqadd_x3", rg(3), 32'd25);
    check("sqadd_pc", pc, 32'hC);

    run(addi(5'd5, 5'd0, 12'd7), 0);
    run(addi(5'd6, 5'd0, 12'd5), 0);
    run(rr(3'b001, 5'd7, 5'd5, 5'd6), 33);
    check("mulsub_x7", rg(7), 32'd28);
    check("mulsub_pc", pc, 32'h18);

    run(addi(5'd9, 5'd0, 12'd1), 0);
    run(rr(3'b001, 5'd5, 5'd9, 5'd0), 33);
    check("mulsub_neg1", rg(5), 32'hFFFFFFFF);
    run(addi(5'd6, 5'd0, 12'd2), 0);
    run(rr(3'b001, 5'd7, 5'd5, 5'd6), 33);
    check("mulsub_wrap", rg(7), 32'hFFFFFFFF);
    check("mulsub2_pc", pc, 32'h28);

    run(addi(5'd20, 5'd0, 12'hF0F), 0);
    run(addi(5'd21, 5'd0, 12'h101), 0);
    run(addi(5'd22, 5'd0, 12'h011), 0);
    run(rr(3'b001, 5'd8, 5'd20, 5'd21), 33);
    check("build_a", rg(8), 32'h000F0F00);
    run(addi(5'd8, 5'd8, 12'h00F), 0);
    run(rr(3'b001, 5'd8, 5'd8, 5'd21), 33);
    run(rr(3'b001, 5'd8, 5'd8, 5'd22), 33);
    run(addi(5'd8, 5'd8, 12'h00F), 0);
    check("build_x8", rg(8), 32'hF0F0F00F);
    check("build_pc", pc, 32'h48);

    run(bitcnt(1'b1, 5'd23, 5'd8), 0);
    check("bitcnt_ones", rg(23), 32'd16);
    run(bitcnt(1'b0, 5'd24, 5'd8), 0);
    check("bitcnt_zeros", rg(24), 32'd16);
    run(bitcnt(1'b0, 5'd25, 5'd0), 0);
    check("bitcnt_allz", rg(25), 32'd32);
    run(xori(5'd26, 5'd8, 12'hFFF), 0);
    check("xori", rg(26), 32'hF0F0FFF0);
    check("xori_pc", pc, 32'h58);
    check("no_illegal", 32'(illegal), 32'd0);

    run(addi(5'd1, 5'd0, 12'd2), 0);
    run(addi(5'd2, 5'd0, 12'd9), 0);
    check("pre_br_pc", pc, 32'h60);
    run(selbr(2'b10, 5'd1, 5'd2, 11'h7F0), 0);
    check("bltu_taken", pc, 32'h50);
    run(addi(5'd1, 5'd0, 12'd9), 0);
    run(selbr(2'b10, 5'd1, 5'd2, 11'h7F0), 0);
    check("bltu_not", pc, 32'h58);
    run(selbr(2'b00, 5'd1, 5'd2, 11'h7F0), 0);
    check("sel_nop", pc, 32'h5C);
    run(selbr(2'b01, 5'd1, 5'd2, 11'h020), 0);
    check("beq_taken", pc, 32'h7C);
    run(selbr(2'b11, 5'd1, 5'd2, 11'h7F0), 0);
    check("bgeu_taken", pc, 32'h6C);

    run(jal2(5'd1, 21'h000008), 0);
    check("jal2_link", rg(1), 32'h70);
    check("jal2_pc", pc, 32'h7C);
    run(jal2(5'd0, 21'h1F8000), 0);
    check("jal2_wrap_pc", pc, 32'hFFFF007C);
    check("jal2_x0", rg(0), 32'h0);

    run({7'b0, 5'd2, 5'd1, 3'b000, 5'd4, 7'h33}, 0);
    check("ill_pulse", 32'(illegal), 32'd1);
    check("ill_pc", pc, 32'hFFFF0080);
    check("ill_x4", rg(4), 32'h0);
    @(negedge clk);
    check("ill_drop", 32'(illegal), 32'd0);
    check("idle_pc", pc, 32'hFFFF0080);
    run(rr(3'b011, 5'd4, 5'd1, 5'd2), 0);
    check("ill_f3_pulse", 32'(illegal), 32'd1);
    check("ill_f3_pc", pc, 32'hFFFF0084);
    check("ill_f3_x4", rg(4), 32'h0);
    check("ignored_x31", rg(31), 32'h0);

    instr       = bsw(rr(3'b000, 5'd3, 5'd1, 5'd2));
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_pc", pc, 32'h0);
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_x3", rg(3), 32'h0);

    instr       = bsw(addi(5'd1, 5'd0, 12'd5));
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr = bsw(addi(5'd2, 5'd1, 12'd1));
    @(posedge clk);
    #1;
    instr = bsw(addi(5'd3, 5'd2, 12'd1));
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("b2b_x1", rg(1), 32'd5);
    check("b2b_x2", rg(2), 32'd6);
    check("b2b_x3", rg(3), 32'd7);
    check("b2b_pc", pc, 32'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
